// File: rtl/vcv_sig_pkg.sv
// Shared types and CRC-32 helpers for the VGA frame signature monitor.
package vcv_sig_pkg;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    CAPTURE  = 1'b1
  } sig_state_t;

  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
  localparam int unsigned CRC_MAX_W  = 64;

  // Non-reflected CRC-32 over the low 'width' bits of data, MSB first.
  function automatic logic [31:0] crc32_step(input logic [31:0]          crc,
                                             input logic [CRC_MAX_W-1:0] data,
                                             input int unsigned          width);
    logic [31:0]          c;
    logic [CRC_MAX_W-1:0] d;
    logic                 fb;
    c = crc;
    d = data << (CRC_MAX_W - width);
    for (int unsigned i = 0; i < CRC_MAX_W; i++) begin
      if (i < width) begin
        fb = c[31] ^ d[CRC_MAX_W-1];
        c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
        d  = d << 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_sig_crc.sv
// Running CRC-32 register: one PW-bit word per enabled cycle, init restarts the signature.
module frame_sig_crc
  import vcv_sig_pkg::*;
#(
  parameter int unsigned PW = 12
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          init,
  input  logic          en,
  input  logic [PW-1:0] data,
  output logic [31:0]   crc
);

  logic [31:0] base;
  logic [31:0] next;

  // A word arriving together with init is folded into the fresh signature.
  always_comb begin
    base = init ? CRC32_INIT : crc;
    next = en ? crc32_step(base, CRC_MAX_W'(data), PW) : base;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      crc <= CRC32_INIT;
    end else if (init || en) begin
      crc <= next;
    end
  end

endmodule

// File: rtl/vga_frame_sig.sv
// VGA frame signature monitor: locks to vsync, measures line/frame timing and
// reports a CRC-32 of every active pixel per complete frame.
module vga_frame_sig
  import vcv_sig_pkg::*;
#(
  parameter int unsigned CW       = 4,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_ACT    = 640,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned V_ACT    = 480
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          pix_en,
  input  logic          hsync,
  input  logic          vsync,
  input  logic [CW-1:0] R,
  input  logic [CW-1:0] G,
  input  logic [CW-1:0] B,
  input  logic          clr,
  input  logic          exp_en,
  input  logic [31:0]   exp_crc,
  output logic          frame_valid,
  output logic [31:0]   frame_crc,
  output logic          frame_match,
  output logic [15:0]   frame_cnt,
  output logic [11:0]   h_meas,
  output logic [11:0]   v_meas,
  output logic          timing_err,
  output logic          locked
);

  localparam int unsigned PW      = 3 * CW;
  localparam logic [11:0] H_A0    = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_A1    = 12'(H_SYNC + H_BP + H_ACT);
  localparam logic [11:0] V_A0    = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_A1    = 12'(V_SYNC + V_BP + V_ACT);
  localparam logic [11:0] H_TOT12 = 12'(H_TOTAL);
  localparam logic [11:0] V_TOT12 = 12'(V_TOTAL);
  localparam logic [19:0] ACT_PIX = 20'(H_ACT * V_ACT);

  sig_state_t  state;
  logic        hs_act, vs_act, hs_prev, vs_prev;
  logic        h_edge, vs_edge;
  logic [11:0] h_cnt, v_cnt, h_next, v_next, h_period, v_period;
  logic [19:0] act_cnt;
  logic        act_pix, h_bad, h_bad_n;
  logic [31:0] crc;

  assign hs_act  = (hsync == SYNC_POL);
  assign vs_act  = (vsync == SYNC_POL);
  assign h_edge  = pix_en && hs_act && !hs_prev;
  assign vs_edge = pix_en && vs_act && !vs_prev;
  assign locked  = (state == CAPTURE);

  // h_next/v_next are the position of the pixel sampled this cycle.
  // v_period counts hsync edges since the last vsync edge, including one
  // coincident with the closing vsync edge, so aligned syncs measure V_TOTAL.
  always_comb begin
    h_period = (h_cnt == '1) ? h_cnt : h_cnt + 12'd1;
    v_period = (h_edge && v_cnt != '1) ? v_cnt + 12'd1 : v_cnt;
    h_next   = h_edge ? '0 : h_period;
    v_next   = vs_edge ? '0 : v_period;
    act_pix  = pix_en && (h_next >= H_A0) && (h_next < H_A1)
                      && (v_next >= V_A0) && (v_next < V_A1);
    h_bad_n  = h_bad || (h_edge && state == CAPTURE && h_period != H_TOT12);
  end

  frame_sig_crc #(.PW(PW)) u_crc (
    .clk    (clk),
    .resetn (resetn),
    .init   (clr || vs_edge),
    .en     (act_pix && !clr),
    .data   ({R, G, B}),
    .crc    (crc)
  );

  always_ff @(posedge clk) begin
    frame_valid <= 1'b0;
    if (!resetn || clr) begin
      state       <= UNLOCKED;
      hs_prev     <= 1'b0;
      vs_prev     <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      act_cnt     <= '0;
      h_bad       <= 1'b0;
      frame_crc   <= '0;
      frame_match <= 1'b0;
      h_meas      <= '0;
      v_meas      <= '0;
      timing_err  <= 1'b0;
      if (!resetn) frame_cnt <= '0;
    end else if (pix_en) begin
      hs_prev <= hs_act;
      vs_prev <= vs_act;
      h_cnt   <= h_next;
      v_cnt   <= v_next;
      if (h_edge) h_meas <= h_period;
      if (vs_edge) begin
        state   <= CAPTURE;
        act_cnt <= act_pix ? 20'd1 : 20'd0;
        h_bad   <= 1'b0;
        if (state == CAPTURE) begin
          frame_valid <= 1'b1;
          frame_crc   <= ~crc;
          frame_match <= exp_en && (~crc == exp_crc);
          frame_cnt   <= frame_cnt + 16'd1;
          v_meas      <= v_period;
          timing_err  <= h_bad_n || (v_period != V_TOT12) || (act_cnt != ACT_PIX);
        end
      end else begin
        h_bad <= h_bad_n;
        if (act_pix && act_cnt != '1) act_cnt <= act_cnt + 20'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_sig.sv
// Bench for vga_frame_sig on a reduced 20x12 raster; active-low and active-high sync builds run side by side.
module tb_vga_frame_sig;

  localparam int HT = 20, HS = 2, HB = 3, HA = 12;
  localparam int VT = 12, VS = 1, VB = 2, VA = 8;

  typedef struct packed {
    logic [31:0] crc;
    logic        match;
    logic [15:0] cnt;
    logic [11:0] hm;
    logic [11:0] vm;
    logic        terr;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0, pix_en = 1'b0, clr = 1'b0, exp_en = 1'b0;
  logic        hsync = 1'b1, vsync = 1'b1, hsync_hi = 1'b0, vsync_hi = 1'b0;
  logic [3:0]  r = '0, g = '0, b = '0;
  logic [31:0] exp_crc = '0;

  logic        frame_valid, frame_match, timing_err, locked;
  logic [31:0] frame_crc;
  logic [15:0] frame_cnt;
  logic [11:0] h_meas, v_meas;
  logic        frame_valid_hi, frame_match_hi, timing_err_hi, locked_hi;
  logic [31:0] frame_crc_hi;
  logic [15:0] frame_cnt_hi;
  logic [11:0] h_meas_hi, v_meas_hi;

  int checks = 0, errors = 0, valid_cnt = 0;
  exp_t exp_q[$], exp_hi_q[$];

  bit          m_locked = 0, m_pending = 0, m_pend_terr = 0;
  logic [15:0] m_cnt = '0;
  logic [31:0] m_pend_crc = '0, m_last_crc = '0, golden = '0;

  vga_frame_sig #(
    .CW(4), .SYNC_POL(1'b0),
    .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACT(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACT(VA)
  ) dut (
    .clk(clk), .resetn(resetn), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .R(r), .G(g), .B(b), .clr(clr), .exp_en(exp_en), .exp_crc(exp_crc),
    .frame_valid(frame_valid), .frame_crc(frame_crc), .frame_match(frame_match),
    .frame_cnt(frame_cnt), .h_meas(h_meas), .v_meas(v_meas),
    .timing_err(timing_err), .locked(locked)
  );

  vga_frame_sig #(
    .CW(4), .SYNC_POL(1'b1),
    .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACT(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACT(VA)
  ) dut_hi (
    .clk(clk), .resetn(resetn), .pix_en(pix_en), .hsync(hsync_hi), .vsync(vsync_hi),
    .R(r), .G(g), .B(b), .clr(clr), .exp_en(exp_en), .exp_crc(exp_crc),
    .frame_valid(frame_valid_hi), .frame_crc(frame_crc_hi), .frame_match(frame_match_hi),
    .frame_cnt(frame_cnt_hi), .h_meas(h_meas_hi), .v_meas(v_meas_hi),
    .timing_err(timing_err_hi), .locked(locked_hi)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tb_crc(input logic [31:0] c_in, input logic [11:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 11; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = (c << 1) ^ 32'h04C1_1DB7;
      else              c = c << 1;
    end
    return c;
  endfunction

  // Scoreboard consumer: each frame_valid pulse pops one expected frame per build.
  always @(negedge clk) begin
    exp_t e, a;
    if (frame_valid) begin
      valid_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_result: unexpected frame_valid, crc=%h cnt=%0d", frame_crc, frame_cnt);
      end else begin
        e = exp_q.pop_front();
        a = {frame_crc, frame_match, frame_cnt, h_meas, v_meas, timing_err};
        if (a !== e) begin
          errors++;
          $display("FAIL frame_result: got crc=%h match=%0d cnt=%0d h=%0d v=%0d terr=%0d, expected crc=%h match=%0d cnt=%0d h=%0d v=%0d terr=%0d",
                   a.crc, a.match, a.cnt, a.hm, a.vm, a.terr, e.crc, e.match, e.cnt, e.hm, e.vm, e.terr);
        end
      end
    end
    if (frame_valid_hi) begin
      checks++;
      if (exp_hi_q.size() == 0) begin
        errors++;
        $display("FAIL frame_result_hi: unexpected frame_valid, crc=%h", frame_crc_hi);
      end else begin
        e = exp_hi_q.pop_front();
        e.cnt = '0;
        a = {frame_crc_hi, frame_match_hi, 16'h0, h_meas_hi, v_meas_hi, timing_err_hi};
        if (a !== e) begin
          errors++;
          $display("FAIL frame_result_hi: got crc=%h match=%0d h=%0d v=%0d terr=%0d, expected crc=%h match=%0d h=%0d v=%0d terr=%0d",
                   a.crc, a.match, a.hm, a.vm, a.terr, e.crc, e.match, e.hm, e.vm, e.terr);
        end
      end
    end
  end

  task automatic close_frame();
    exp_t e;
    if (m_locked && m_pending) begin
      m_cnt   = m_cnt + 16'd1;
      e.crc   = m_pend_crc;
      e.match = exp_en && (m_pend_crc == exp_crc);
      e.cnt   = m_cnt;
      e.hm    = 12'(HT);
      e.vm    = 12'(VT);
      e.terr  = m_pend_terr;
      exp_q.push_back(e);
      exp_hi_q.push_back(e);
      m_last_crc = m_pend_crc;
    end
    m_locked  = 1;
    m_pending = 0;
  endtask

  task automatic drive_pix(input bit hs, input bit vs, input logic [11:0] px, input bit half);
    hsync = ~hs; vsync = ~vs; hsync_hi = hs; vsync_hi = vs;
    {r, g, b} = px;
    pix_en = 1'b1;
    @(negedge clk);
    if (half) begin
      pix_en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    pix_en = 1'b0; clr = 1'b0;
    hsync = 1'b1; vsync = 1'b1; hsync_hi = 1'b0; vsync_hi = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    m_locked = 0; m_pending = 0; m_cnt = '0;
  endtask

  // ev_kind: 0 none, 1 reset pulse, 2 clr pulse; applied at pixel 10 of line ev_line.
  task automatic drive_frame(input logic [11:0] col, input int short_line, input int flip_line,
                             input int flip_px, input bit half, input int ev_kind, input int ev_line);
    logic [31:0] c;
    logic [11:0] px;
    int          len;
    bit          ev;
    c = 32'hFFFF_FFFF;
    for (int l = 0; l < VT; l++) begin
      len = (l == short_line) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        px = (l == flip_line && p == flip_px) ? ~col : col;
        if (l == 0 && p == 0) close_frame();
        ev = (ev_kind != 0 && l == ev_line && p == 10);
        if (ev && ev_kind == 1) resetn = 1'b0;
        if (ev && ev_kind == 2) clr = 1'b1;
        drive_pix(p < HS, l < VS, px, half);
        if (l >= VS + VB && l < VS + VB + VA && p >= HS + HB && p < HS + HB + HA)
          c = tb_crc(c, px);
        if (ev) begin
          resetn = 1'b1;
          clr    = 1'b0;
          m_locked = 0; m_pending = 0;
          if (ev_kind == 1) m_cnt = '0;
          checks++;
          if ({frame_valid, frame_crc, frame_match, h_meas, v_meas, timing_err, locked} !== '0) begin
            errors++;
            $display("FAIL sync_clear_outputs: got crc=%h h=%0d v=%0d terr=%0d locked=%0d, required all 0",
                     frame_crc, h_meas, v_meas, timing_err, locked);
          end
          checks++;
          if (frame_cnt !== m_cnt) begin
            errors++;
            $display("FAIL sync_clear_frame_cnt: got %0d, required %0d", frame_cnt, m_cnt);
          end
        end
      end
    end
    m_pend_crc  = ~c;
    m_pend_terr = (short_line >= 0);
    m_pending   = 1;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0 || exp_hi_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d/%0d expected frames never reported, required 0",
               name, exp_q.size(), exp_hi_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({frame_valid, frame_crc, frame_match, frame_cnt, h_meas, v_meas, timing_err, locked} !== '0) begin
      errors++;
      $display("FAIL reset_state: got crc=%h cnt=%0d h=%0d v=%0d locked=%0d, required all 0",
               frame_crc, frame_cnt, h_meas, v_meas, locked);
    end
    checks++;
    if ({frame_valid_hi, frame_crc_hi, frame_cnt_hi, h_meas_hi, v_meas_hi, locked_hi} !== '0) begin
      errors++;
      $display("FAIL reset_state_hi: got crc=%h cnt=%0d locked=%0d, required all 0",
               frame_crc_hi, frame_cnt_hi, locked_hi);
    end
  endtask

  task automatic test_basic();
    int v0;
    do_reset();
    v0 = valid_cnt;
    for (int f = 0; f < 3; f++) drive_frame(12'hF0A, -1, -1, -1, 0, 0, 0);
    golden = m_last_crc;
    checks++;
    if (valid_cnt - v0 != 2) begin
      errors++;
      $display("FAIL basic_valid_count: got %0d, required 2", valid_cnt - v0);
    end
    checks++;
    if ({frame_cnt, h_meas, v_meas, timing_err, locked} !== {16'd2, 12'(HT), 12'(VT), 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL basic_hold: got cnt=%0d h=%0d v=%0d terr=%0d locked=%0d, required 2 %0d %0d 0 1",
               frame_cnt, h_meas, v_meas, timing_err, locked, HT, VT);
    end
    check_drained("basic");
  endtask

  task automatic test_match();
    exp_crc = golden;
    exp_en  = 1'b1;
    drive_frame(12'hF0A, -1, -1, -1, 0, 0, 0);
    drive_frame(12'hF0A, -1, 5, 8, 0, 0, 0);
    drive_frame(12'hF0A, -1, -1, -1, 0, 0, 0);
    checks++;
    if (frame_match !== 1'b0) begin
      errors++;
      $display("FAIL match_flipped_pixel: got frame_match=%0d, required 0", frame_match);
    end
    exp_en = 1'b0;
    check_drained("match");
  endtask

  task automatic test_short_line();
    drive_frame(12'h3C5, -1, -1, -1, 0, 0, 0);
    drive_frame(12'h3C5, 4, -1, -1, 0, 0, 0);
    drive_frame(12'h3C5, -1, -1, -1, 0, 0, 0);
    drive_frame(12'h3C5, -1, -1, -1, 0, 0, 0);
    checks++;
    if (timing_err !== 1'b0) begin
      errors++;
      $display("FAIL short_line_recovery: got timing_err=%0d, required 0", timing_err);
    end
    check_drained("short_line");
  endtask

  task automatic test_reset_midframe();
    int v0;
    drive_frame(12'h777, -1, -1, -1, 0, 1, 6);
    v0 = valid_cnt;
    drive_frame(12'h777, -1, -1, -1, 0, 0, 0);
    checks++;
    if (valid_cnt != v0) begin
      errors++;
      $display("FAIL reset_first_edge: got %0d frame_valid pulses, required 0", valid_cnt - v0);
    end
    drive_frame(12'h777, -1, -1, -1, 0, 0, 0);
    checks++;
    if (valid_cnt - v0 != 1) begin
      errors++;
      $display("FAIL reset_second_edge: got %0d frame_valid pulses, required 1", valid_cnt - v0);
    end
    drive_frame(12'h123, -1, -1, -1, 0, 2, 3);
    drive_frame(12'h123, -1, -1, -1, 0, 0, 0);
    drive_frame(12'h123, -1, -1, -1, 0, 0, 0);
    check_drained("reset_midframe");
  endtask

  task automatic test_half_rate();
    do_reset();
    for (int f = 0; f < 3; f++) drive_frame(12'hF0A, -1, -1, -1, 1, 0, 0);
    checks++;
    if ({frame_crc, h_meas, v_meas} !== {golden, 12'(HT), 12'(VT)}) begin
      errors++;
      $display("FAIL half_rate: got crc=%h h=%0d v=%0d, required crc=%h h=%0d v=%0d",
               frame_crc, h_meas, v_meas, golden, HT, VT);
    end
    checks++;
    if ({frame_crc_hi, h_meas_hi, v_meas_hi} !== {golden, 12'(HT), 12'(VT)}) begin
      errors++;
      $display("FAIL half_rate_hi: got crc=%h h=%0d v=%0d, required crc=%h h=%0d v=%0d",
               frame_crc_hi, h_meas_hi, v_meas_hi, golden, HT, VT);
    end
    check_drained("half_rate");
  endtask

  task automatic test_wrap();
    int v0;
    do_reset();
    drive_frame(12'h0F0, -1, -1, -1, 0, 0, 0);
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    m_cnt = 16'hFFFF;
    v0 = valid_cnt;
    drive_frame(12'h0F0, -1, -1, -1, 0, 0, 0);
    checks++;
    if (valid_cnt - v0 != 1) begin
      errors++;
      $display("FAIL wrap_valid_count: got %0d, required 1", valid_cnt - v0);
    end
    checks++;
    if (frame_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_frame_cnt: got %h, required 0000", frame_cnt);
    end
    check_drained("wrap");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_match();
    test_short_line();
    test_reset_midframe();
    test_half_rate();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
